// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divide controller: FSM state
// encoding and the default iteration count.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIVZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } div_state_e;

  localparam int unsigned DIV_CYCLES = 32;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend
// bit, trial-subtract the divisor, keep the difference when non-negative.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The extra top bit carries the sign of the trial subtraction.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU controller beside the E-stage ALU: runs a WIDTH-step restoring
// divide, stalls the pipeline while busy, and delivers {remainder, quotient}.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_CYCLES
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  // quo_q doubles as the dividend shift register; its MSB feeds each step.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !annul_i) state_d = (opb_i == '0) ? DIVZERO : ON;
      DIVZERO: state_d = annul_i ? IDLE : END;
      ON: begin
        if (annul_i)                        state_d = IDLE;
        else if (cnt_q == CW'(WIDTH - 1))   state_d = END;
      end
      END:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept  = (state_q == IDLE) && start_i && !annul_i;
    a_neg   = signed_i && opa_i[WIDTH-1];
    b_neg   = signed_i && opb_i[WIDTH-1];
    fix_quo = neg_quo_q ? ('0 - quo_q) : quo_q;
    fix_rem = neg_rem_q ? ('0 - rem_q) : rem_q;
    stall_o = start_i && !annul_i && (state_q != END);
    ready_o = (state_q == END) && !annul_i;
    result_o = ready_o ? {fix_rem, fix_quo} : result_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          neg_rem_d = a_neg;
          neg_quo_d = a_neg ^ b_neg;
          quo_d     = a_neg ? ('0 - opa_i) : opa_i;
          dvs_d     = b_neg ? ('0 - opb_i) : opb_i;
          rem_d     = '0;
          cnt_d     = '0;
        end
      end
      ON: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
      end
      // Rebuild the raw dividend from its latched magnitude so the
      // remainder is opa exactly; fix-up is disabled for this result.
      DIVZERO: begin
        rem_d     = neg_rem_q ? ('0 - quo_q) : quo_q;
        quo_d     = '1;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
      end
      END: begin
        if (!annul_i) result_d = {fix_rem, fix_quo};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table of divides run back-to-back,
// plus annul and asynchronous-reset sequences.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int unsigned lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Entered at posedge+1 (cycle 0); leaves at posedge+1 of the cycle after END.
  task automatic run_div(input vec_t v, input int idx);
    start_i  = 1'b1;
    signed_i = v.sgn;
    opa_i    = v.a;
    opb_i    = v.b;
    annul_i  = 1'b0;
    for (int c = 0; c <= int'(v.lat); c++) begin
      #3;
      if (c == 0) chk($sformatf("v%0d state_c0", idx), 64'(dut.state_q), 64'(IDLE));
      chk($sformatf("v%0d stall_c%0d", idx, c), 64'(stall_o), (c < int'(v.lat)) ? 64'd1 : 64'd0);
      chk($sformatf("v%0d ready_c%0d", idx, c), 64'(ready_o), (c == int'(v.lat)) ? 64'd1 : 64'd0);
      if (c == int'(v.lat)) chk($sformatf("v%0d result", idx), result_o, {v.r, v.q});
      @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] prior;

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
    vecs[2] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          2};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[4] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          33};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
    vecs[6] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33};
    vecs[7] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};
    vecs[8] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};

    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    opa_i    = '0;
    opb_i    = '0;
    annul_i  = 1'b0;
    #12;
    chk("rst result", result_o, 64'd0);
    chk("rst ready", 64'(ready_o), 64'd0);
    chk("rst state", 64'(dut.state_q), 64'(IDLE));
    chk("rst stall_lo", 64'(stall_o), 64'd0);
    start_i = 1'b1;
    #1;
    chk("rst stall_follows", 64'(stall_o), 64'd1);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // start_i stays high between entries, so each one is accepted on the
    // IDLE cycle directly after the previous END.
    for (int i = 0; i < 10; i++) run_div(vecs[i], i);
    prior = {vecs[9].r, vecs[9].q};
    start_i = 1'b0;
    @(posedge clk);
    #1;

    // Annul during ON at cycle 10.
    start_i  = 1'b1;
    signed_i = 1'b0;
    opa_i    = 32'd1000;
    opb_i    = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) annul_i = 1'b1;
      #3;
      if (c == 10) chk("annul_on stall", 64'(stall_o), 64'd0);
      @(posedge clk);
      #1;
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    #3;
    chk("annul_on state_c11", 64'(dut.state_q), 64'(IDLE));
    begin
      int unsigned seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (ready_o || result_o !== prior) seen++;
        @(posedge clk);
        #3;
      end
      chk("annul_on quiet40", 64'(seen), 64'd0);
    end
    chk("annul_on result_kept", result_o, prior);
    @(posedge clk);
    #1;

    // Annul arriving on the END cycle.
    start_i = 1'b1;
    opa_i   = 32'd50;
    opb_i   = 32'd5;
    for (int c = 0; c <= 33; c++) begin
      if (c == 33) annul_i = 1'b1;
      #3;
      if (c == 33) begin
        chk("annul_end state", 64'(dut.state_q), 64'(END));
        chk("annul_end ready", 64'(ready_o), 64'd0);
        chk("annul_end result", result_o, prior);
      end
      @(posedge clk);
      #1;
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    #3;
    chk("annul_end state_after", 64'(dut.state_q), 64'(IDLE));
    chk("annul_end result_after", result_o, prior);
    @(posedge clk);
    #1;

    // Asynchronous reset on cycle 15 of a divide, then a clean 20/6.
    start_i = 1'b1;
    opa_i   = 32'd1000;
    opb_i   = 32'd7;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rstmid state_before", 64'(dut.state_q), 64'(ON));
    resetn = 1'b0;
    #1;
    chk("rstmid state", 64'(dut.state_q), 64'(IDLE));
    chk("rstmid result", result_o, 64'd0);
    chk("rstmid ready", 64'(ready_o), 64'd0);
    chk("rstmid cnt", 64'(dut.cnt_q), 64'd0);
    chk("rstmid stall_follows", 64'(stall_o), 64'd1);
    start_i = 1'b0;
    #1;
    chk("rstmid stall_lo", 64'(stall_o), 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    begin
      vec_t v;
      v = '{1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33};
      run_div(v, 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide controller for the five-stage MIPS pipeline. It sits beside the execute-stage ALU and runs DIV/DIVU as a 32-iteration restoring divider under a small FSM. While the divide is in flight it raises a stall request that the hazard logic ORs into the fetch, decode and execute stall terms. On completion it delivers the {remainder, quotient} pair destined for HI/LO.

## Interface
- `WIDTH`, default 32: operand width. Iteration count equals `WIDTH`.
- `clk`  in  1  pipeline clock. All state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  level-sensitive. A DIV/DIVU is in the E stage.
- `signed_i`  in  1  1 = DIV, 0 = DIVU. Sampled when leaving IDLE.
- `opa_i`  in  WIDTH  dividend (rs). Sampled when leaving IDLE.
- `opb_i`  in  WIDTH  divisor (rt). Sampled when leaving IDLE.
- `annul_i`  in  1  exception or flush of the E-stage instruction. Aborts the divide.
- `stall_o`  out  1  combinational stall request to the hazard unit.
- `ready_o`  out  1  one-cycle pulse: `result_o` is valid this cycle.
- `result_o`  out  2*WIDTH  registered {remainder, quotient}.

## Operation
- States: IDLE, DIVZERO, ON, END. Encoding and `DIV_CYCLES` come from the package.
- IDLE, with `start_i & ~annul_i`:
  - Latch `signed_i`.
  - Latch |opa| and |opb| when signed, raw values otherwise.
  - Clear the counter.
  - Go to DIVZERO if `opb_i == 0`, otherwise go to ON.
- ON: one restoring step per cycle.
  - Shift the partial remainder left and bring in the next dividend bit.
  - Subtract the divisor. If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Counter increments each step. After step `WIDTH` (counter == WIDTH-1), go to END.
- DIVZERO: load quotient = all-ones and remainder = dividend (unmodified opa), then go to END.
- END:
  - Signed fix-up: quotient is negated if the operand signs differ; remainder is negated if the dividend is negative.
  - Write `result_o`, pulse `ready_o`, return to IDLE.
  - In END, `start_i` is ignored.
- `stall_o = start_i & ~annul_i & (state != END)`. The pipeline therefore advances on the END cycle.
- `annul_i` high in ON or DIVZERO: return to IDLE next edge. No `ready_o`, `result_o` unchanged.
- `annul_i` high in END: suppress `ready_o` and the `result_o` update, return to IDLE.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Two's-complement wrap, no trap.
- Arithmetic: partial remainder is WIDTH+1 bits to hold the subtract sign. All other paths are WIDTH bits, with no carries beyond that.

## Timing
- Reset: state=IDLE, counter=0, `result_o`=0, `ready_o`=0. `stall_o` then follows `start_i`.
- Reset mid-operation discards all progress immediately, because reset is asynchronous.
- Normal latency, with the accept cycle as cycle 0:
  - cycles 1..32 are ON;
  - END and `ready_o` fall on cycle 33;
  - `stall_o` is high on cycles 0..32 and low on cycle 33.
- Divide-by-zero latency: DIVZERO on cycle 1, END and `ready_o` on cycle 2.
- `result_o` holds its value until the next non-annulled END.
- Back-to-back divides: a new `start_i` on the cycle after END is accepted from IDLE with no bubble beyond the IDLE cycle.

## Structure
- Shared package holds:
  - the state typedef/constants: IDLE=2'b00, DIVZERO=2'b01, ON=2'b10, END=2'b11;
  - `DIV_CYCLES`.
- One sub-module is natural: `div_step`, a combinational single restoring step. Inputs: partial remainder, next dividend bit, divisor. Outputs: next remainder, quotient bit.
- Sign handling, the counter and the FSM stay in `div_ctrl`.

## Test plan
- DIVU 100/7 with `start_i` held → `stall_o` high on cycles 0..32. `ready_o` on cycle 33 with quotient 14, remainder 2.
- DIV -7/2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, at cycle 33.
- DIVU 5/0 → `ready_o` on cycle 2, quotient 0xFFFFFFFF, remainder 5.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Then an immediate second DIVU 9/3 is accepted on the next cycle → quotient 3, remainder 0.
- `annul_i` pulsed on cycle 10 of a divide → state IDLE at cycle 11. No `ready_o` for 40 cycles, `result_o` keeps the prior value.
- `resetn` low on cycle 15 of a divide → outputs 0 and state IDLE immediately. After release, 20/6 completes normally: quotient 3, remainder 2.
